// File: rtl/alu_scheduler.sv
// Two-requester sequencer for the shared ALU: grants one operation, holds its operands
// for a settling cycle, captures result/flags, returns a tagged response.
// Optional build macro: ALU_SCHED_FIXED_PRIO_EN (req0 always wins ties; default is round-robin).
module alu_scheduler #(
  parameter int OPW = 3,
  parameter int DW  = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           req1_ready,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_arith,
  input  logic [DW-1:0]  alu_comp,
  input  logic           alu_z,
  input  logic           alu_v,
  input  logic           alu_n,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_y,
  output logic           rsp_z,
  output logic           rsp_v,
  output logic           rsp_n,
  output logic [7:0]     ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   gnt_id;
  logic   accept;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    gnt_id = ~req0_valid & req1_valid;
`else
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = req1_valid;
`endif
    case (state)
      IDLE: begin
        // Reset gates ready so nothing is handshaken while the block is held in reset.
        if (!reset && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_n      <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        alu_op     <= gnt_id ? req1_op : req0_op;
        alu_a      <= gnt_id ? req1_a  : req0_a;
        alu_b      <= gnt_id ? req1_b  : req0_b;
        last_grant <= gnt_id;
        rsp_id     <= gnt_id;
      end
      // Ops 0 and 1 are arithmetic; everything else reads the comparison unit.
      if (state == EXEC) begin
        rsp_y <= (alu_op == '0 || alu_op == OPW'(1)) ? alu_arith : alu_comp;
        rsp_z <= alu_z;
        rsp_v <= alu_v;
        rsp_n <= alu_n;
      end
      if (state == RESP && rsp_ready) ops_done <= ops_done + 8'd1;
    end
  end

endmodule
